// File: rtl/song_pkg.sv
// rtl/song_pkg.sv - song sequencer shared widths, state encoding and end-of-song marker
package song_pkg;

    localparam int SONG_W_DEF = 2;
    localparam int IDX_W_DEF  = 5;
    localparam int NOTE_W_DEF = 6;
    localparam int DUR_W_DEF  = 6;

    // A duration of zero marks the end of a song in the ROM.
    localparam int END_DUR = 0;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_ISSUE     = 3'd2,
        S_WAIT_NOTE = 3'd3,
        S_DONE      = 3'd4
    } state_t;

endpackage

// File: rtl/dffr.sv
// rtl/dffr.sv - W-bit flop with synchronous active-high clear and load enable
module dffr #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/note_index_counter.sv
// rtl/note_index_counter.sv - note index counter with sync clear, increment enable and terminal flag
module note_index_counter #(
    parameter int IDX_W = 5
) (
    input  logic             clk,
    input  logic             clear,   // synchronous, wins over inc
    input  logic             inc,     // advance by one; ignored at terminal count
    output logic [IDX_W-1:0] index,
    output logic             last     // index is at its final value
);

    logic [IDX_W-1:0] index_plus;

    assign last       = &index;
    assign index_plus = index + IDX_W'(1);

    // Saturates at the terminal count: the last note of a song never wraps to entry 0.
    dffr #(.W(IDX_W)) u_index (
        .clk   (clk),
        .reset (clear),
        .en    (inc && !last),
        .d     (index_plus),
        .q     (index)
    );

endmodule

// File: rtl/song_sequencer.sv
// rtl/song_sequencer.sv - fetches song ROM words and issues notes to the player (optional SONG_SEQ_PREFETCH_EN)
module song_sequencer
    import song_pkg::*;
#(
    parameter int SONG_W = SONG_W_DEF,
    parameter int IDX_W  = IDX_W_DEF,
    parameter int NOTE_W = NOTE_W_DEF,
    parameter int DUR_W  = DUR_W_DEF
) (
    input  logic                    clk,
    input  logic                    reset,         // synchronous, active-high
    input  logic                    play,          // 1 = playing, 0 = paused
    input  logic                    reset_player,  // restart current song
    input  logic [SONG_W-1:0]       song,          // song select, latched in IDLE
    input  logic                    note_done,     // pulse: current note finished
    output logic [SONG_W+IDX_W-1:0] rom_addr,      // {song_lat, index}
    input  logic [NOTE_W+DUR_W-1:0] rom_data,      // {note, duration}, one cycle after rom_addr
    output logic                    new_note,      // pulse: note/duration newly issued
    output logic [NOTE_W-1:0]       note,
    output logic [DUR_W-1:0]        duration,
    output logic                    song_done      // pulse: end of song
);

    localparam int WORD_W = NOTE_W + DUR_W;

    logic              clr;
    logic [2:0]        state_q;
    state_t            state;
    state_t            state_next;
    logic [SONG_W-1:0] song_lat;
    logic [IDX_W-1:0]  index;
    logic [IDX_W-1:0]  index_plus;
    logic              idx_last;
    logic              idx_inc;
    logic              load;
    logic              done_pulse;
    logic [WORD_W-1:0] issue_word;
    logic [NOTE_W-1:0] issue_note;
    logic [DUR_W-1:0]  issue_dur;

    // reset_player restarts the song exactly as a full reset would.
    assign clr        = reset | reset_player;
    assign state      = state_t'(state_q);
    assign index_plus = index + IDX_W'(1);
    assign issue_note = issue_word[WORD_W-1:DUR_W];
    assign issue_dur  = issue_word[DUR_W-1:0];

    dffr #(.W(3)) u_state (
        .clk   (clk),
        .reset (clr),
        .en    (1'b1),
        .d     (state_next),
        .q     (state_q)
    );

    // The selected song tracks the controller while idle and is frozen once playback starts.
    dffr #(.W(SONG_W)) u_song_lat (
        .clk   (clk),
        .reset (1'b0),
        .en    (clr || state == S_IDLE),
        .d     (song),
        .q     (song_lat)
    );

    note_index_counter #(.IDX_W(IDX_W)) u_index (
        .clk   (clk),
        .clear (clr),
        .inc   (idx_inc),
        .index (index),
        .last  (idx_last)
    );

    dffr #(.W(NOTE_W)) u_note (
        .clk   (clk),
        .reset (clr),
        .en    (load),
        .d     (issue_note),
        .q     (note)
    );

    dffr #(.W(DUR_W)) u_duration (
        .clk   (clk),
        .reset (clr),
        .en    (load),
        .d     (issue_dur),
        .q     (duration)
    );

    dffr #(.W(1)) u_new_note (
        .clk   (clk),
        .reset (clr),
        .en    (1'b1),
        .d     (load),
        .q     (new_note)
    );

    dffr #(.W(1)) u_song_done (
        .clk   (clk),
        .reset (clr),
        .en    (1'b1),
        .d     (done_pulse),
        .q     (song_done)
    );

`ifdef SONG_SEQ_PREFETCH_EN
    localparam state_t AFTER_WAIT = S_ISSUE;

    logic              wait_q;
    logic              pf_used;
    logic [WORD_W-1:0] pf_word;

    // While waiting, the ROM is already addressed at the next entry. Its data is only
    // trustworthy once that address has been held for a cycle, hence wait_q; if the note
    // ends sooner, ISSUE falls back to rom_data, which by then belongs to the new index.
    dffr #(.W(1)) u_wait_q (
        .clk   (clk),
        .reset (clr),
        .en    (1'b1),
        .d     (state == S_WAIT_NOTE),
        .q     (wait_q)
    );

    dffr #(.W(1)) u_pf_used (
        .clk   (clk),
        .reset (clr),
        .en    (1'b1),
        .d     (state == S_WAIT_NOTE && wait_q),
        .q     (pf_used)
    );

    dffr #(.W(WORD_W)) u_pf_word (
        .clk   (clk),
        .reset (clr),
        .en    (state == S_WAIT_NOTE),
        .d     (rom_data),
        .q     (pf_word)
    );

    assign issue_word = pf_used ? pf_word : rom_data;
    // No look-ahead past the last entry: the song ends there instead of wrapping.
    assign rom_addr   = (state == S_WAIT_NOTE && !idx_last) ? {song_lat, index_plus}
                                                            : {song_lat, index};
`else
    localparam state_t AFTER_WAIT = S_FETCH;

    assign issue_word = rom_data;
    assign rom_addr   = {song_lat, index};
`endif

    always_comb begin
        state_next = state;
        load       = 1'b0;
        done_pulse = 1'b0;
        idx_inc    = 1'b0;
        case (state)
            S_IDLE: begin
                if (play) begin
                    state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                state_next = S_ISSUE;
            end
            S_ISSUE: begin
                if (issue_dur == DUR_W'(END_DUR)) begin
                    state_next = S_DONE;
                    done_pulse = 1'b1;
                end else if (play) begin
                    load       = 1'b1;
                    state_next = S_WAIT_NOTE;
                end
            end
            S_WAIT_NOTE: begin
                // Pause is not applied here; the note player gates its own timing.
                if (note_done) begin
                    if (idx_last) begin
                        state_next = S_DONE;
                        done_pulse = 1'b1;
                    end else begin
                        idx_inc    = 1'b1;
                        state_next = AFTER_WAIT;
                    end
                end
            end
            S_DONE: begin
                state_next = S_DONE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_song_sequencer.sv
// tb/tb_song_sequencer.sv - self-checking bench for song_sequencer
module tb_song_sequencer;

`ifdef SONG_SEQ_PREFETCH_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        play;
    logic        reset_player;
    logic [1:0]  song;
    logic        note_done;
    logic [6:0]  rom_addr;
    logic [11:0] rom_data;
    logic        new_note;
    logic [5:0]  note;
    logic [5:0]  duration;
    logic        song_done;

    logic [11:0] rom [128];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic play;
        logic nd;
        int   addr;
        logic nn;
        int   nt;
        int   du;
        logic sd;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom[rom_addr];

    song_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .play         (play),
        .reset_player (reset_player),
        .song         (song),
        .note_done    (note_done),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .new_note     (new_note),
        .note         (note),
        .duration     (duration),
        .song_done    (song_done)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t v(input logic p, input logic nd, input int a, input logic nn,
                               input int nt, input int du, input logic sd);
        vec_t r;
        r.play = p; r.nd = nd; r.addr = a; r.nn = nn; r.nt = nt; r.du = du; r.sd = sd;
        return r;
    endfunction

    task automatic do_reset(input logic [1:0] s);
        reset = 1'b1; reset_player = 1'b0; play = 1'b0; note_done = 1'b0; song = s;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Reference: the song is the ROM entries of the selected song up to the first zero
    // duration (or all 32), issued in order, followed by exactly one song_done.
    task automatic run_song(input int s, input int zpos);
        logic [11:0] exp_q[$];
        logic [11:0] w;
        int  cd, nd_it, done_cnt, extra;
        bit  busy, lat_ok, prev_play;
        for (int i = 0; i < 32; i++) begin
            w[11:6] = 6'($urandom);
            w[5:0]  = (i == zpos) ? 6'd0 : 6'($urandom_range(1, 63));
            rom[s*32 + i] = w;
            if (i < zpos) exp_q.push_back(w);
        end
        reset_player = 1'b1; song = 2'(s); play = 1'b0; note_done = 1'b0;
        @(negedge clk);
        reset_player = 1'b0; play = 1'b1;
        busy = 0; cd = 0; nd_it = -100; lat_ok = 0; done_cnt = 0; extra = 0; prev_play = 1;
        for (int it = 0; it < 3000 && extra < 12; it++) begin
            @(negedge clk);
            if (new_note) begin
                check("issue only while playing", int'(prev_play), 1);
                check("note expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    w = exp_q.pop_front();
                    check($sformatf("song%0d note word", s), int'({note, duration}), int'(w));
                end
                // note_done applied in iteration nd_it is sampled on the following edge
                if (lat_ok) check("note_done to new_note latency", it - nd_it, LAT + 1);
                busy = 1;
                cd = $urandom_range(0, 3);
                lat_ok = 0;
            end
            if (song_done) begin
                done_cnt++;
                check("all notes issued at song_done", exp_q.size(), 0);
                if (nd_it >= 0)
                    check("song_done latency", it - nd_it, (zpos < 32) ? LAT + 1 : 1);
            end
            if (done_cnt > 0) extra++;
            song = 2'($urandom);
            play = ($urandom_range(0, 3) != 0);
            note_done = 1'b0;
            if (busy) begin
                if (cd == 0) begin
                    note_done = 1'b1; busy = 0; nd_it = it; lat_ok = 1;
                end else begin
                    cd--;
                end
            end else if ($urandom_range(0, 4) == 0) begin
                note_done = 1'b1;  // stray pulse outside WAIT_NOTE must be ignored
            end
            if (it >= nd_it && it <= nd_it + LAT && !play) lat_ok = 0;
            prev_play = play;
        end
        check("run ended within budget", extra, 12);
        check($sformatf("song%0d song_done pulses", s), done_cnt, 1);
        if (zpos >= 32) check("index held at last entry", int'(rom_addr), s*32 + 31);
        note_done = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cnt;
        reset = 1'b1; reset_player = 1'b0; play = 1'b0; note_done = 1'b0; song = 2'd2;
        for (int i = 0; i < 128; i++) rom[i] = 12'h001;
        rom[64] = {6'd5, 6'd8};
        rom[65] = {6'd9, 6'd3};
        rom[66] = {6'd7, 6'd0};
        rom[0]  = {6'd3, 6'd4};
        repeat (2) @(negedge clk);
        reset = 1'b0;

        check("reset rom_addr", int'(rom_addr), 64);
        check("reset new_note", int'(new_note), 0);
        check("reset note", int'(note), 0);
        check("reset duration", int'(duration), 0);
        check("reset song_done", int'(song_done), 0);

        // play, note 64, note_done, note 65, end marker at 66, later note_done ignored
`ifdef SONG_SEQ_PREFETCH_EN
        vecs.push_back(v(1, 0, 64, 0, 0, 0, 0));
        vecs.push_back(v(1, 0, 64, 0, 0, 0, 0));
        vecs.push_back(v(1, 0, 65, 1, 5, 8, 0));
        vecs.push_back(v(1, 0, 65, 0, 5, 8, 0));
        vecs.push_back(v(1, 1, 65, 0, 5, 8, 0));
        vecs.push_back(v(1, 0, 66, 1, 9, 3, 0));
        vecs.push_back(v(1, 0, 66, 0, 9, 3, 0));
        vecs.push_back(v(1, 0, 66, 0, 9, 3, 0));
        vecs.push_back(v(1, 1, 66, 0, 9, 3, 0));
        vecs.push_back(v(1, 0, 66, 0, 9, 3, 1));
        vecs.push_back(v(1, 1, 66, 0, 9, 3, 0));
        vecs.push_back(v(1, 0, 66, 0, 9, 3, 0));
`else
        vecs.push_back(v(1, 0, 64, 0, 0, 0, 0));
        vecs.push_back(v(1, 0, 64, 0, 0, 0, 0));
        vecs.push_back(v(1, 0, 64, 1, 5, 8, 0));
        vecs.push_back(v(1, 0, 64, 0, 5, 8, 0));
        vecs.push_back(v(1, 1, 65, 0, 5, 8, 0));
        vecs.push_back(v(1, 0, 65, 0, 5, 8, 0));
        vecs.push_back(v(1, 0, 65, 1, 9, 3, 0));
        vecs.push_back(v(1, 0, 65, 0, 9, 3, 0));
        vecs.push_back(v(1, 1, 66, 0, 9, 3, 0));
        vecs.push_back(v(1, 0, 66, 0, 9, 3, 0));
        vecs.push_back(v(1, 0, 66, 0, 9, 3, 1));
        vecs.push_back(v(1, 1, 66, 0, 9, 3, 0));
        vecs.push_back(v(1, 0, 66, 0, 9, 3, 0));
`endif
        foreach (vecs[k]) begin
            play = vecs[k].play;
            note_done = vecs[k].nd;
            @(negedge clk);
            check($sformatf("vec%0d rom_addr", k), int'(rom_addr), vecs[k].addr);
            check($sformatf("vec%0d new_note", k), int'(new_note), int'(vecs[k].nn));
            check($sformatf("vec%0d note", k), int'(note), vecs[k].nt);
            check($sformatf("vec%0d duration", k), int'(duration), vecs[k].du);
            check($sformatf("vec%0d song_done", k), int'(song_done), int'(vecs[k].sd));
        end

        // Pause while a note is ready: no issue for 10 cycles, then issue on resume.
        do_reset(2'd0);
        play = 1'b1;
        @(negedge clk);
        play = 1'b0;
        @(negedge clk);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (new_note) cnt++;
        end
        check("paused issue pulses", cnt, 0);
        check("paused rom_addr", int'(rom_addr), 0);
        play = 1'b1;
        @(negedge clk);
        check("resume new_note", int'(new_note), 1);
        check("resume note", int'(note), 3);
        check("resume duration", int'(duration), 4);

        // reset_player coincident with note_done, new song selected.
        note_done = 1'b1; reset_player = 1'b1; song = 2'd1;
        @(negedge clk);
        note_done = 1'b0; reset_player = 1'b0; play = 1'b0;
        check("restart rom_addr", int'(rom_addr), 32);
        check("restart note", int'(note), 0);
        check("restart duration", int'(duration), 0);
        check("restart new_note", int'(new_note), 0);
        @(negedge clk);
        check("restart index not advanced", int'(rom_addr), 32);

        run_song(3, 32);
        run_song(1, 0);
        run_song(0, 1);
        run_song(2, $urandom_range(2, 31));
        run_song($urandom_range(0, 3), 32);
        run_song(1, $urandom_range(1, 31));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/song_sequencer.md
Name: song_sequencer

Overview:
- Fetches note/duration words for the currently selected song from the song ROM and hands them one at a time to the note player.
- Sits between the play/pause/next controller (inputs `play`, `reset_player`, `song`; output `song_done`) and the note player (handshake `new_note` / `note_done`).
- Owns the note index, the end-of-song detection and the play gating of note issue.

Parameters:
- SONG_W, 2, song select width
- IDX_W, 5, note index width (32 notes per song)
- NOTE_W, 6, note code width
- DUR_W, 6, duration width in beats; 0 = end-of-song marker

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- play  in  1  high = playing; low = paused
- reset_player  in  1  synchronous restart of current song; same effect as reset on all sequencer state
- song  in  SONG_W  song select from controller
- note_done  in  1  one-cycle pulse from note player: current note finished
- rom_addr  out  SONG_W+IDX_W  {song_lat, index}; combinational from registers
- rom_data  in  NOTE_W+DUR_W  {note, duration}; ROM is synchronous, valid 1 cycle after rom_addr
- new_note  out  1  one-cycle pulse: note/duration are valid and newly issued
- note  out  NOTE_W  current note, held until next issue
- duration  out  DUR_W  current duration, held until next issue
- song_done  out  1  one-cycle pulse at end of song

Behaviour:
- Single clock `clk`. Reset is synchronous and active-high on port `reset`.
- reset or reset_player (highest priority, synchronous), next cycle:
  - state=IDLE, index=0, song_lat=song
  - new_note=0, song_done=0, note=0, duration=0
- States: IDLE, FETCH, ISSUE, WAIT_NOTE, DONE.
- IDLE:
  - song_lat=song every cycle.
  - play=1 -> FETCH.
- FETCH:
  - rom_addr={song_lat,index} presented; ROM data arrives next cycle.
  - Always -> ISSUE.
- ISSUE:
  - rom_data[DUR_W-1:0]==0 -> DONE, song_done=1 for 1 cycle, no new_note.
  - Else if play=1:
    - register note/duration from rom_data; pulse new_note.
    - -> WAIT_NOTE.
  - Else (play=0): hold in ISSUE, no pulse, rom_addr unchanged.
- WAIT_NOTE:
  - note_done=1 and index==2^IDX_W-1 -> DONE, song_done pulse (no wrap).
  - note_done=1 otherwise: index+=1 -> FETCH.
  - play=0 does not block note_done; the note player does its own pause gating.
- DONE:
  - Hold; song_done stays 0 after its single pulse.
  - Exit only via reset or reset_player.
- Latency: note_done at cycle t -> new_note at t+2 (play=1).
- song is ignored outside IDLE; a song change takes effect only after reset_player.
- note_done while not in WAIT_NOTE is ignored.
- reset_player in the same cycle as note_done: reset wins, and index is not incremented.

Optional Feature:
- Macro: SONG_SEQ_PREFETCH_EN
- Defined:
  - During WAIT_NOTE, rom_addr={song_lat,index+1} and rom_data is captured into a prefetch register.
  - On note_done, go directly to ISSUE using the prefetched word.
  - note_done at t -> new_note at t+1.
  - When index==2^IDX_W-1, there is no prefetch (no wrap) and the last-note rule applies.
- Undefined:
  - Behaviour as above, with 2-cycle latency.
  - No prefetch register.

Decomposition:
- Package song_pkg:
  - state encoding constants (IDLE, FETCH, ISSUE, WAIT_NOTE, DONE)
  - SONG_W, IDX_W, NOTE_W, DUR_W defaults
  - END_DUR=0
- Registers built from the existing dffr flop module.
- One natural sub-module: note_index_counter (IDX_W counter with sync clear, increment enable and terminal-count flag).

Test Plan:
- Reset; play=1, song=2; ROM[64]={note 5, dur 8} -> rom_addr=64, new_note at cycle 3 after play with note=5, duration=8.
- Issue done and ROM[65] valid; note_done pulse at t -> index=1, rom_addr=65, new_note at t+2 (t+1 with SONG_SEQ_PREFETCH_EN).
- ROM[66] duration=0 -> no new_note; song_done single pulse; state DONE; later note_done is ignored.
- play=0 while in ISSUE for 10 cycles -> no new_note; play=1 -> new_note next cycle.
- reset_player in WAIT_NOTE coincident with note_done, song changed to 1 -> index=0, rom_addr=32 after restart, note/duration=0.
- All 32 entries nonzero duration -> after 32nd note_done, song_done pulse; index stays 31 and does not wrap.
